// File: rtl/vec_ec_pkg.sv
// Shared constants and forward (symbol -> codeNum) tables for the vector entropy coder.
package vec_ec_pkg;

    localparam int unsigned VEC_GRK_B1      = 1;
    localparam int unsigned VEC_GRK_B2      = 5;
    localparam int unsigned VEC_EC_MAX_SIZE = 13;

    // Index is the 4-bit symbol, value is codeNum.
    localparam logic [3:0] FWD_LUMA_B1 [16] = '{
        4'd15, 4'd1,  4'd0,  4'd4,  4'd2,  4'd5,  4'd6,  4'd9,
        4'd3,  4'd7,  4'd8,  4'd11, 4'd10, 4'd12, 4'd13, 4'd14
    };

    localparam logic [3:0] FWD_CHROMA_B1 [16] = '{
        4'd0,  4'd1,  4'd2,  4'd5,  4'd3,  4'd6,  4'd7,  4'd10,
        4'd4,  4'd8,  4'd9,  4'd12, 4'd11, 4'd13, 4'd14, 4'd15
    };

    // 256-entry tables are closed-form permutations of the 8-bit symbol.
    function automatic logic [7:0] fwd_luma_b2(input logic [7:0] sym);
        return sym - 8'd1;
    endfunction

    function automatic logic [7:0] fwd_chroma_b2(input logic [7:0] sym);
        return {sym[5:0], 2'b00} + sym + 8'd3;
    endfunction

    typedef struct packed {
        logic [7:0] sym;
        logic [1:0] br;
        logic       err;
    } s1_t;

endpackage

// File: rtl/vec_ec_gr_pack.sv
// Golomb-Rice style assembly: prefix ones, a zero, then vec_grk suffix bits, MSB-aligned.
module vec_ec_gr_pack
    import vec_ec_pkg::*;
(
    input  logic [7:0]  code_num,
    input  logic [2:0]  vec_grk,
    output logic [15:0] codeword,
    output logic [7:0]  size
);

    logic [2:0] prefix;
    logic [7:0] suffix;
    logic [3:0] shift;

    always_comb begin
        prefix   = 3'(code_num >> vec_grk);
        suffix   = code_num & ~(8'hFF << vec_grk);
        shift    = 4'd15 - 4'(prefix) - 4'(vec_grk);
        codeword = ~(16'hFFFF >> prefix) | (16'(suffix) << shift);
        size     = 8'(prefix) + 8'd1 + 8'(vec_grk);
    end

endmodule

// File: rtl/enc_vec_ec_symbol_2c.sv
// Two-stage vector symbol encoder for groups of four two's-complement samples.
// Define ENC_VEC_EC_STATS_EN to enable the saturating emitted-bit counter on stat_bits.
module enc_vec_ec_symbol_2c
    import vec_ec_pkg::*;
#(
    parameter int ssm_idx = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        bitsReq,
    input  logic signed [8:0] src_0,
    input  logic signed [8:0] src_1,
    input  logic signed [8:0] src_2,
    input  logic signed [8:0] src_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       codeword,
    output logic [7:0]        size,
    output logic              err,
    output logic [31:0]       stat_bits
);

    localparam bit LUMA = (ssm_idx == 1);

    // A sample fits when all bits above the field's sign bit replicate it.
    function automatic logic fits(input logic [8:0] s, input logic [1:0] br);
        if (br == 2'd1) return (&s) | ~(|s);
        return (&s[8:1]) | ~(|s[8:1]);
    endfunction

    s1_t         s1_d, s1_q;
    logic        s1_valid, s2_valid, adv;
    logic [7:0]  code_num;
    logic [2:0]  vec_grk;
    logic [15:0] pk_cw;
    logic [7:0]  pk_size;

    assign adv       = !s2_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = s2_valid;

    always_comb begin
        s1_d.br  = bitsReq;
        s1_d.err = !((bitsReq == 2'd1) || (bitsReq == 2'd2)) ||
                   !fits(src_0, bitsReq) || !fits(src_1, bitsReq) ||
                   !fits(src_2, bitsReq) || !fits(src_3, bitsReq);
        if (bitsReq == 2'd1)
            s1_d.sym = {4'b0000, src_0[0], src_1[0], src_2[0], src_3[0]};
        else
            s1_d.sym = {src_0[1:0], src_1[1:0], src_2[1:0], src_3[1:0]};
    end

    always_comb begin
        code_num = '0;
        vec_grk  = 3'(VEC_GRK_B1);
        if (s1_q.br == 2'd2) begin
            vec_grk  = 3'(VEC_GRK_B2);
            code_num = LUMA ? fwd_luma_b2(s1_q.sym) : fwd_chroma_b2(s1_q.sym);
        end else begin
            code_num = {4'b0000, LUMA ? FWD_LUMA_B1[s1_q.sym[3:0]]
                                      : FWD_CHROMA_B1[s1_q.sym[3:0]]};
        end
    end

    vec_ec_gr_pack u_pack (
        .code_num (code_num),
        .vec_grk  (vec_grk),
        .codeword (pk_cw),
        .size     (pk_size)
    );

    // Both stages move on the same enable, so stage 1 refills as stage 2 drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            codeword <= '0;
            size     <= '0;
            err      <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) s1_q <= s1_d;
            s2_valid <= s1_valid;
            if (s1_valid) begin
                codeword <= s1_q.err ? '0 : pk_cw;
                size     <= s1_q.err ? '0 : pk_size;
                err      <= s1_q.err;
            end
        end
    end

`ifdef ENC_VEC_EC_STATS_EN
    logic [31:0] stat_q;
    logic [32:0] stat_sum;

    assign stat_sum  = {1'b0, stat_q} + 33'(size);
    assign stat_bits = stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stat_q <= '0;
        else if (s2_valid && out_ready)
            stat_q <= stat_sum[32] ? '1 : stat_sum[31:0];
    end
`else
    assign stat_bits = '0;
`endif

endmodule

// File: tb/tb_enc_vec_ec_symbol_2c.sv
// Scoreboard bench driving a luma and a chroma instance with identical stimulus.
module tb_enc_vec_ec_symbol_2c;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [1:0]        bits_req = 2'd1;
    logic signed [8:0] src_0 = '0, src_1 = '0, src_2 = '0, src_3 = '0;
    logic              out_ready = 1'b0;

    logic        l_in_ready, l_out_valid, l_err, c_in_ready, c_out_valid, c_err;
    logic [15:0] l_codeword, c_codeword;
    logic [7:0]  l_size, c_size;
    logic [31:0] l_stat, c_stat;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    enc_vec_ec_symbol_2c #(.ssm_idx(1)) u_luma (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .bitsReq(bits_req), .src_0(src_0), .src_1(src_1), .src_2(src_2), .src_3(src_3),
        .out_valid(l_out_valid), .out_ready(out_ready), .codeword(l_codeword),
        .size(l_size), .err(l_err), .stat_bits(l_stat)
    );

    enc_vec_ec_symbol_2c #(.ssm_idx(0)) u_chroma (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .bitsReq(bits_req), .src_0(src_0), .src_1(src_1), .src_2(src_2), .src_3(src_3),
        .out_valid(c_out_valid), .out_ready(out_ready), .codeword(c_codeword),
        .size(c_size), .err(c_err), .stat_bits(c_stat)
    );

    // Decoder symbol tables: index is codeNum, value is symbol.
    localparam logic [3:0] DEC_L1 [16] = '{4'd2, 4'd1, 4'd4, 4'd8, 4'd3, 4'd5, 4'd6, 4'd9,
                                           4'd10, 4'd7, 4'd12, 4'd11, 4'd13, 4'd14, 4'd15, 4'd0};
    localparam logic [3:0] DEC_C1 [16] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd5, 4'd6,
                                           4'd9, 4'd10, 4'd7, 4'd12, 4'd11, 4'd13, 4'd14, 4'd15};

    function automatic int dec_sym(input int br, input bit luma, input int c);
        if (br == 1) return luma ? int'(DEC_L1[c]) : int'(DEC_C1[c]);
        if (luma) return (c + 1) & 255;
        return ((c - 3) * 205) & 255;
    endfunction

    function automatic int enc_code(input int br, input bit luma, input int sym);
        for (int c = 0; c < ((br == 1) ? 16 : 256); c++)
            if (dec_sym(br, luma, c) == sym) return c;
        return -1;
    endfunction

    function automatic logic [15:0] gr_word(input int c, input int grk);
        logic [15:0] w = '0;
        int pos = 15;
        for (int i = 0; i < (c >> grk); i++) begin w[pos] = 1'b1; pos--; end
        pos--;
        for (int i = grk - 1; i >= 0; i--) begin w[pos] = 1'((c >> i) & 1); pos--; end
        return w;
    endfunction

    function automatic int decode_cw(input logic [15:0] w, input int br, input bit luma,
                                     output int sz);
        int pos = 15;
        int pre = 0;
        int grk = (br == 2) ? 5 : 1;
        int c;
        while (pos >= 0 && w[pos]) begin pre++; pos--; end
        if (pre > 7 || pos < grk) begin sz = -1; return -1; end
        pos--;
        c = pre;
        for (int i = 0; i < grk; i++) begin c = (c << 1) | int'(w[pos]); pos--; end
        sz = pre + 1 + grk;
        return dec_sym(br, luma, c);
    endfunction

    typedef struct {
        logic        err;
        logic [15:0] cw_l, cw_c;
        logic [7:0]  sz_l, sz_c;
        int          sym, br;
    } exp_t;

    exp_t   sb[$];
    exp_t   m;
    longint exp_stat_l = 0, exp_stat_c = 0;
    bit     hold_pend = 1'b0;
    logic [15:0] h_cw;
    logic [7:0]  h_sz;
    logic        h_err;
    int     d_sym, d_sz;

    function automatic logic [31:0] stat_exp(input bit luma);
`ifdef ENC_VEC_EC_STATS_EN
        return luma ? 32'(exp_stat_l) : 32'(exp_stat_c);
`else
        return 32'd0;
`endif
    endfunction

    task automatic put(input logic [1:0] br, input int v0, input int v1, input int v2, input int v3);
        exp_t e;
        int   vs[4];
        int   lo, hi, grk, cl, cc;
        bit   ok = 1'b0;
        vs = '{v0, v1, v2, v3};
        bits_req = br;
        src_0 = 9'(v0); src_1 = 9'(v1); src_2 = 9'(v2); src_3 = 9'(v3);
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (l_in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_total++;
        if (!ok) $display("FAIL accept_timeout: in_ready=%b, required 1 within 100 cycles", l_in_ready);
        else n_pass++;
        e.br  = int'(br);
        e.sym = 0;
        e.err = !(br == 2'd1 || br == 2'd2);
        if (!e.err) begin
            lo = -(1 << (br - 1));
            hi = (1 << (br - 1)) - 1;
            foreach (vs[i]) begin
                if (vs[i] < lo || vs[i] > hi) e.err = 1'b1;
                e.sym = (e.sym << br) | (vs[i] & ((1 << br) - 1));
            end
        end
        if (e.err) begin
            e.cw_l = '0; e.cw_c = '0; e.sz_l = '0; e.sz_c = '0;
        end else begin
            grk = (br == 2'd2) ? 5 : 1;
            cl = enc_code(e.br, 1'b1, e.sym);
            cc = enc_code(e.br, 1'b0, e.sym);
            e.cw_l = gr_word(cl, grk);
            e.cw_c = gr_word(cc, grk);
            e.sz_l = 8'((cl >> grk) + 1 + grk);
            e.sz_c = 8'((cc >> grk) + 1 + grk);
        end
        if (ok) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                n_total++;
                if ({l_out_valid, l_codeword, l_size, l_err} !== {1'b1, h_cw, h_sz, h_err})
                    $display("FAIL hold_stable: got v=%b cw=%h sz=%0d err=%b, required v=1 cw=%h sz=%0d err=%b",
                             l_out_valid, l_codeword, l_size, l_err, h_cw, h_sz, h_err);
                else n_pass++;
            end
            n_total++;
            if (l_out_valid !== c_out_valid)
                $display("FAIL valid_match: chroma out_valid=%b, required %b", c_out_valid, l_out_valid);
            else n_pass++;
            if (l_out_valid && out_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL spurious_output: out_valid=1 with empty scoreboard, required 0");
                end else begin
                    n_pass++;
                    m = sb.pop_front();
                    n_total++;
                    if ({l_err, l_codeword, l_size} !== {m.err, m.cw_l, m.sz_l})
                        $display("FAIL luma_out: got err=%b cw=%h sz=%0d, required err=%b cw=%h sz=%0d",
                                 l_err, l_codeword, l_size, m.err, m.cw_l, m.sz_l);
                    else n_pass++;
                    n_total++;
                    if ({c_err, c_codeword, c_size} !== {m.err, m.cw_c, m.sz_c})
                        $display("FAIL chroma_out: got err=%b cw=%h sz=%0d, required err=%b cw=%h sz=%0d",
                                 c_err, c_codeword, c_size, m.err, m.cw_c, m.sz_c);
                    else n_pass++;
                    if (!m.err) begin
                        d_sym = decode_cw(l_codeword, m.br, 1'b1, d_sz);
                        n_total++;
                        if (d_sym != m.sym || d_sz != int'(l_size))
                            $display("FAIL luma_decode: got sym=%0d sz=%0d, required sym=%0d sz=%0d",
                                     d_sym, d_sz, m.sym, l_size);
                        else n_pass++;
                        d_sym = decode_cw(c_codeword, m.br, 1'b0, d_sz);
                        n_total++;
                        if (d_sym != m.sym || d_sz != int'(c_size))
                            $display("FAIL chroma_decode: got sym=%0d sz=%0d, required sym=%0d sz=%0d",
                                     d_sym, d_sz, m.sym, c_size);
                        else n_pass++;
                    end
                    exp_stat_l += longint'(m.sz_l);
                    exp_stat_c += longint'(m.sz_c);
                    if (exp_stat_l > 64'hFFFF_FFFF) exp_stat_l = 64'hFFFF_FFFF;
                    if (exp_stat_c > 64'hFFFF_FFFF) exp_stat_c = 64'hFFFF_FFFF;
                end
            end
            hold_pend = l_out_valid && !out_ready;
            h_cw = l_codeword; h_sz = l_size; h_err = l_err;
        end
    end

    task automatic drain(input string tag);
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !l_out_valid) begin done = 1'b1; break; end
        end
        n_total++;
        if (!done) $display("FAIL %s_drain: %0d groups outstanding, required 0", tag, sb.size());
        else n_pass++;
        n_total++;
        if (l_stat !== stat_exp(1'b1) || c_stat !== stat_exp(1'b0))
            $display("FAIL %s_stat: got luma=%0d chroma=%0d, required luma=%0d chroma=%0d",
                     tag, l_stat, c_stat, stat_exp(1'b1), stat_exp(1'b0));
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_total++;
        if ({l_out_valid, l_codeword, l_size, l_err, l_stat} !== '0)
            $display("FAIL reset_state: got v=%b cw=%h sz=%0d err=%b stat=%0d, required all 0",
                     l_out_valid, l_codeword, l_size, l_err, l_stat);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_known();
        logic [1:0]  k_br [10] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd2};
        int          k_v  [10][4] = '{'{0, 0, -1, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 1}, '{0, 0, 0, 0},
                                      '{2, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{1, 0, 0, 0},
                                      '{-3, 0, 0, 0}, '{-2, 1, -1, 0}};
        logic [15:0] k_cw [10] = '{16'h0000, 16'hFE80, 16'h0000, 16'hFEF8, 16'h0000,
                                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hF6C0};
        logic [7:0]  k_sz [10] = '{8'd2, 8'd9, 8'd6, 8'd13, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10};
        logic        k_er [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(k_br[i], k_v[i][0], k_v[i][1], k_v[i][2], k_v[i][3]);
            @(negedge clk);
            n_total++;
            if (l_out_valid !== 1'b0)
                $display("FAIL known%0d_early: out_valid=%b one cycle after accept, required 0", i, l_out_valid);
            else n_pass++;
            @(posedge clk); #1;
            @(negedge clk);
            n_total++;
            if ({l_out_valid, l_err, l_codeword, l_size} !== {1'b1, k_er[i], k_cw[i], k_sz[i]})
                $display("FAIL known%0d: got v=%b err=%b cw=%h sz=%0d, required v=1 err=%b cw=%h sz=%0d",
                         i, l_out_valid, l_err, l_codeword, l_size, k_er[i], k_cw[i], k_sz[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        drain("known");
    endtask

    task automatic test_back_to_back();
        int pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        fork
            begin
                for (int g = 0; g < 8; g++) begin
                    int br = int'($urandom_range(1, 2));
                    int v[4];
                    foreach (v[i]) v[i] = int'($urandom_range(0, (1 << br) - 1)) - (1 << (br - 1));
                    put(2'(br), v[0], v[1], v[2], v[3]);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = pat[k % 8][0];
                    @(posedge clk); #1;
                end
            end
        join
        drain("back_to_back");
    endtask

    task automatic test_exhaustive();
        out_ready = 1'b1;
        for (int br = 1; br <= 2; br++) begin
            for (int sym = 0; sym < (1 << (4 * br)); sym++) begin
                int v[4];
                foreach (v[i]) begin
                    v[i] = (sym >> (br * (3 - i))) & ((1 << br) - 1);
                    if (v[i] >= (1 << (br - 1))) v[i] -= (1 << br);
                end
                put(2'(br), v[0], v[1], v[2], v[3]);
            end
        end
        drain("exhaustive");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        put(2'd2, 1, -2, 0, -1);
        put(2'd1, -1, 0, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({l_out_valid, l_codeword, l_size, l_err} !== '0)
            $display("FAIL reset_async: got v=%b cw=%h sz=%0d err=%b, required all 0",
                     l_out_valid, l_codeword, l_size, l_err);
        else n_pass++;
        sb.delete();
        exp_stat_l = 0;
        exp_stat_c = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (l_out_valid !== 1'b0 || c_out_valid !== 1'b0)
            $display("FAIL reset_flush: out_valid luma=%b chroma=%b after deassert, required 0",
                     l_out_valid, c_out_valid);
        else n_pass++;
        @(posedge clk); #1;
        put(2'd1, 0, 0, 0, 0);
        drain("reset_mid");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known();
        test_back_to_back();
        test_exhaustive();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
